// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential non-restoring divider.
package divider_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_STEP = 3'd2,
    S_CORR = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Width of the step counter; it must hold WIDTH-1.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/div_addsub.sv
// Combinational N-bit adder/subtractor shared by the step and correction phases.
module div_addsub #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum
);

  logic [N-1:0] b_eff;
  logic [N-1:0] cin;

  assign b_eff = b ^ {N{sub}};
  assign cin   = {{(N-1){1'b0}}, sub};
  assign sum   = a + b_eff + cin;

endmodule

// File: rtl/nonrestoring_divider.sv
// Unsigned radix-2 non-restoring divider, WIDTH+3 cycles start-to-done; starts only accepted in S_IDLE, no queuing.
// NONRESTORING_DIVIDER_DIV0_DETECT_EN: zero divisor short-circuits S_LOAD -> S_DONE and raises div0sig.
module nonrestoring_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             beginsig,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busysig,
  output logic             donesig,
  output logic             div0sig
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   a_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] hold_dd;
  logic [WIDTH-1:0] hold_dv;

  logic [WIDTH:0]   as_a;
  logic [WIDTH:0]   as_b;
  logic             as_sub;
  logic [WIDTH:0]   as_sum;

  // Step: operate on the shifted partial remainder; correction: add M back to A.
  always_comb begin
    as_a   = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    as_sub = ~a_reg[WIDTH];
    if (state == S_CORR) begin
      as_a   = a_reg;
      as_sub = 1'b0;
    end
  end

  assign as_b = {1'b0, m_reg};

  div_addsub #(.N(WIDTH + 1)) u_addsub (
    .a   (as_a),
    .b   (as_b),
    .sub (as_sub),
    .sum (as_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      a_reg     <= '0;
      q_reg     <= '0;
      m_reg     <= '0;
      hold_dd   <= '0;
      hold_dv   <= '0;
      quotient  <= '0;
      remainder <= '0;
      busysig   <= 1'b0;
      donesig   <= 1'b0;
    end else begin
      donesig <= 1'b0;
      case (state)
        S_IDLE: begin
          if (beginsig) begin
            hold_dd <= dividend;
            hold_dv <= divisor;
            busysig <= 1'b1;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          a_reg <= '0;
          q_reg <= hold_dd;
          m_reg <= hold_dv;
          cnt   <= CW'(WIDTH - 1);
`ifdef NONRESTORING_DIVIDER_DIV0_DETECT_EN
          if (hold_dv == '0) begin
            quotient  <= '1;
            remainder <= hold_dd;
            busysig   <= 1'b0;
            donesig   <= 1'b1;
            state     <= S_DONE;
          end else begin
            state <= S_STEP;
          end
`else
          state <= S_STEP;
`endif
        end
        S_STEP: begin
          a_reg <= as_sum;
          q_reg <= {q_reg[WIDTH-2:0], ~as_sum[WIDTH]};
          if (cnt == '0) begin
            state <= S_CORR;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_CORR: begin
          if (a_reg[WIDTH]) begin
            a_reg     <= as_sum;
            remainder <= as_sum[WIDTH-1:0];
          end else begin
            remainder <= a_reg[WIDTH-1:0];
          end
          quotient <= q_reg;
          busysig  <= 1'b0;
          donesig  <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef NONRESTORING_DIVIDER_DIV0_DETECT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      div0sig <= 1'b0;
    end else if (state == S_IDLE && beginsig) begin
      div0sig <= 1'b0;
    end else if (state == S_LOAD && hold_dv == '0) begin
      div0sig <= 1'b1;
    end
  end
`else
  assign div0sig = 1'b0;
`endif

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Randomized self-checking bench for nonrestoring_divider against an arithmetic reference model.
module tb_nonrestoring_divider;

  localparam int W = 8;
`ifdef NONRESTORING_DIVIDER_DIV0_DETECT_EN
  localparam bit DZ = 1'b1;
`else
  localparam bit DZ = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         beginsig;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busysig;
  logic         donesig;
  logic         div0sig;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nonrestoring_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .beginsig  (beginsig),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busysig   (busysig),
    .donesig   (donesig),
    .div0sig   (div0sig)
  );

  function automatic logic [W-1:0] ref_q(input logic [W-1:0] dd, input logic [W-1:0] dv);
    return (dv == 0) ? {W{1'b1}} : W'(int'(dd) / int'(dv));
  endfunction

  function automatic logic [W-1:0] ref_r(input logic [W-1:0] dd, input logic [W-1:0] dv);
    return (dv == 0) ? dd : W'(int'(dd) % int'(dv));
  endfunction

  function automatic int ref_lat(input logic [W-1:0] dv);
    return (DZ && dv == 0) ? 2 : W + 3;
  endfunction

  function automatic int ref_busy(input logic [W-1:0] dv);
    return (DZ && dv == 0) ? 1 : W + 2;
  endfunction

  // Start a division and count cycles until donesig; lat=40 means no completion.
  task automatic run_div(input logic [W-1:0] dd, input logic [W-1:0] dv, input bit hold,
                         output int lat, output int busy_n);
    @(negedge clk);
    dividend = dd;
    divisor  = dv;
    beginsig = 1'b1;
    lat    = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!hold) beginsig = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
      if (busysig === 1'b1) busy_n++;
    end while (donesig !== 1'b1 && lat < 40);
  endtask

  task automatic test_reset();
    rst = 1'b1; beginsig = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({quotient, remainder, busysig, donesig, div0sig} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got q=%0d r=%0d busy=%b done=%b div0=%b, want all 0",
               quotient, remainder, busysig, donesig, div0sig);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [W-1:0] td [6];
    logic [W-1:0] tv [6];
    int lat, busy_n;
    td = '{8'd100, 8'd255, 8'd5, 8'd255, 8'd42, 8'd0};
    tv = '{8'd7,   8'd1,   8'd9, 8'd255, 8'd0,  8'd13};
    for (int i = 0; i < 6; i++) begin
      run_div(td[i], tv[i], 1'b0, lat, busy_n);
      checks++;
      if (quotient !== ref_q(td[i], tv[i])) begin
        errors++;
        $display("FAIL dir_quotient %0d/%0d: got %0d want %0d", td[i], tv[i], quotient, ref_q(td[i], tv[i]));
      end
      checks++;
      if (remainder !== ref_r(td[i], tv[i])) begin
        errors++;
        $display("FAIL dir_remainder %0d/%0d: got %0d want %0d", td[i], tv[i], remainder, ref_r(td[i], tv[i]));
      end
      checks++;
      if (lat != ref_lat(tv[i])) begin
        errors++;
        $display("FAIL dir_latency %0d/%0d: got %0d want %0d", td[i], tv[i], lat, ref_lat(tv[i]));
      end
      checks++;
      if (busy_n != ref_busy(tv[i])) begin
        errors++;
        $display("FAIL dir_busy_cycles %0d/%0d: got %0d want %0d", td[i], tv[i], busy_n, ref_busy(tv[i]));
      end
      checks++;
      if (div0sig !== (DZ && tv[i] == 0)) begin
        errors++;
        $display("FAIL dir_div0 %0d/%0d: got %b want %b", td[i], tv[i], div0sig, (DZ && tv[i] == 0));
      end
      @(negedge clk);
      checks++;
      if (donesig !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse_width %0d/%0d: got %b want 0", td[i], tv[i], donesig);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, busy_n, gap;
    run_div(8'd100, 8'd7, 1'b1, lat, busy_n);
    checks++;
    if (quotient !== 8'd14 || remainder !== 8'd2 || lat != W + 3) begin
      errors++;
      $display("FAIL held_begin_run: got q=%0d r=%0d lat=%0d want q=14 r=2 lat=%0d", quotient, remainder, lat, W + 3);
    end
    dividend = 8'd200;
    divisor  = 8'd3;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (donesig !== 1'b1 && gap < 40);
    beginsig = 1'b0;
    checks++;
    if (gap != W + 4) begin
      errors++;
      $display("FAIL restart_gap: got %0d want %0d", gap, W + 4);
    end
    checks++;
    if (quotient !== 8'd66 || remainder !== 8'd2) begin
      errors++;
      $display("FAIL second_run: got q=%0d r=%0d want q=66 r=2", quotient, remainder);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat, busy_n;
    @(negedge clk);
    dividend = 8'd100; divisor = 8'd7; beginsig = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      beginsig = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({quotient, remainder, busysig, donesig, div0sig} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got q=%0d r=%0d busy=%b done=%b div0=%b, want all 0",
               quotient, remainder, busysig, donesig, div0sig);
    end
    run_div(8'd200, 8'd3, 1'b0, lat, busy_n);
    checks++;
    if (quotient !== 8'd66 || remainder !== 8'd2 || lat != W + 3) begin
      errors++;
      $display("FAIL after_reset_run: got q=%0d r=%0d lat=%0d want q=66 r=2 lat=%0d", quotient, remainder, lat, W + 3);
    end
    @(negedge clk);
  endtask

  task automatic test_rst_and_begin();
    int busy_seen;
    @(negedge clk);
    rst = 1'b1; beginsig = 1'b1; dividend = 8'd9; divisor = 8'd2;
    @(negedge clk);
    rst = 1'b0; beginsig = 1'b0;
    busy_seen = 0;
    for (int k = 0; k < 3; k++) begin
      if (busysig !== 1'b0) busy_seen++;
      @(negedge clk);
    end
    checks++;
    if (busy_seen != 0) begin
      errors++;
      $display("FAIL rst_beats_begin: busy seen in %0d cycles, want 0", busy_seen);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] corners [4];
    logic [W-1:0] dd, dv;
    int lat, busy_n;
    corners = '{8'd0, 8'd1, 8'd255, 8'd128};
    for (int i = 0; i < 2000; i++) begin
      dd = ($urandom_range(0, 4) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
      dv = ($urandom_range(0, 4) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
      run_div(dd, dv, 1'b0, lat, busy_n);
      checks++;
      if (quotient !== ref_q(dd, dv) || remainder !== ref_r(dd, dv)) begin
        errors++;
        $display("FAIL rand_result %0d/%0d: got q=%0d r=%0d want q=%0d r=%0d",
                 dd, dv, quotient, remainder, ref_q(dd, dv), ref_r(dd, dv));
      end
      checks++;
      if (lat != ref_lat(dv)) begin
        errors++;
        $display("FAIL rand_latency %0d/%0d: got %0d want %0d", dd, dv, lat, ref_lat(dv));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_rst_and_begin();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
